led_pattern_sequencer: RTL and testbench
========================================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 200_000_000, clock cycles per pattern step (1 s at 200 MHz).
REQ-002 SHALL have parameter BYTE_TIMEOUT, default 1_000_000, maximum idle cycles between bytes of one command.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  received UART byte.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 SHALL have port tx_data  output  8  response byte to UART transmitter.
REQ-008 SHALL have port tx_valid  output  1  response valid; held until tx_ready.
REQ-009 SHALL have port tx_ready  input  1  transmitter accepts tx_data when tx_valid and tx_ready are both high.
REQ-010 SHALL have port led_data  output  8  pattern to LED driver.
REQ-011 SHALL have port led_valid  output  1  one-cycle strobe, led_data updated.
REQ-012 SHALL have port mode  output  2  current mode: 0 static, 1 blink, 2 chase.
REQ-013 SHALL have port err  output  1  sticky error flag.

Function
REQ-014 Command frame SHALL be three bytes: header 0xA5, cmd, arg.
REQ-015 Parser FSM states SHALL be IDLE, CMD, ARG, ACK; IDLE->CMD on rx_valid with 0xA5; other bytes in IDLE discarded, no error.
REQ-016 CMD->ARG on rx_valid, capturing cmd; ARG->ACK on rx_valid, capturing arg and executing the command.
REQ-017 cmd 0x01 STATIC: pattern=arg, mode=0; 0x02 BLINK: pattern=arg, mode=1; 0x03 CHASE: pattern=arg, mode=2; 0x04 CLEAR: pattern=0x00, mode=0, arg ignored.
REQ-018 Valid command: tx_data=0x06 (ACK); unknown cmd: no state change, tx_data=0x15 (NAK), err set.
REQ-019 Execution latency: if arg rx_valid is high in cycle N, led_data=new value, led_valid=1, tx_valid=1 in cycle N+1 (valid cmd only; unknown cmd sets only tx_valid).
REQ-020 ACK state SHALL hold tx_valid and tx_data stable until the cycle where tx_ready=1, then go to IDLE with tx_valid=0 next cycle.
REQ-021 rx_valid in ACK state: byte dropped, err set.
REQ-022 In CMD or ARG, BYTE_TIMEOUT cycles with no rx_valid: return to IDLE, err set, no response.
REQ-023 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick = counter at TICK_DIV-1; counter restarts at 0 on every executed valid command.
REQ-024 Blink: command execution shows pattern (phase on); each tick toggles phase; led_data = pattern when on, 0x00 when off; led_valid pulses each tick.
REQ-025 Chase: each tick led_data rotates left by one (bit7->bit0); led_valid pulses each tick; pattern 0x00 remains 0x00 with pulses.
REQ-026 Static: no led_valid on tick.
REQ-027 Tick and command execution in same cycle: execution wins, tick discarded.
REQ-028 err SHALL be cleared only by reset.

Reset
REQ-029 Reset SHALL force IDLE, led_data=0x00, led_valid=0, tx_data=0x00, tx_valid=0, mode=0, err=0, counter=0, phase on.
REQ-030 Reset asserted mid-frame or in ACK SHALL abandon the frame and drop any pending response.

Verification
REQ-031 TICK_DIV=4: send A5 01 3C -> one cycle after arg: led_data=0x3C, led_valid=1, tx_valid=1, tx_data=0x06; no further led_valid.
REQ-032 TICK_DIV=4: send A5 03 81 -> led_data 0x81, then 0x03, 0x07? no: 0x03, 0x06, 0x0C at successive 4-cycle ticks, one led_valid each.
REQ-033 TICK_DIV=4: send A5 02 F0 -> led_data 0xF0, 0x00, 0xF0 at successive ticks, mode=1.
REQ-034 Send A5 07 11 -> tx_data=0x15, err=1, led_data and mode unchanged, no led_valid.
REQ-035 tx_ready held low 10 cycles after command; send byte during ACK -> tx_valid held, tx_data stable, err=1; tx_ready=1 -> tx_valid=0 next cycle, FSM IDLE.
REQ-036 BYTE_TIMEOUT=8: send A5 only, wait 8 cycles -> err=1, then A5 04 00 accepted normally with led_data=0x00, tx_data=0x06.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
// Bus bundle for led_pattern_sequencer.
// rx_data/rx_valid : byte stream from the UART receiver.
// tx_data/tx_valid/tx_ready : response byte to the UART transmitter (valid/ready).
// led_data/led_valid : pattern to the LED driver, strobed on every update.
// mode/err : current display mode and sticky error flag.
// The master modport is the environment (UART + LED driver); slave is the sequencer.
interface led_pattern_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] led_data;
  logic       led_valid;
  logic [1:0] mode;
  logic       err;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, led_data, led_valid, mode, err
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, led_data, led_valid, mode, err
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// UART-commanded LED pattern sequencer.
// Parses 3-byte frames (0xA5, cmd, arg), applies static/blink/chase/clear commands,
// answers ACK (0x06) or NAK (0x15) and steps animated patterns every TICK_DIV cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of led_pattern_sequencer_if (rx, tx handshake, LED, mode, err)
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV     = 200_000_000,
  parameter int unsigned BYTE_TIMEOUT = 1_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  led_pattern_sequencer_if.slave  bus
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IdleW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(BYTE_TIMEOUT - 1);

  localparam logic [7:0] Header   = 8'hA5;
  localparam logic [7:0] RespAck  = 8'h06;
  localparam logic [7:0] RespNak  = 8'h15;
  localparam logic [7:0] CmdStat  = 8'h01;
  localparam logic [7:0] CmdBlink = 8'h02;
  localparam logic [7:0] CmdChase = 8'h03;
  localparam logic [7:0] CmdClear = 8'h04;

  typedef enum logic [1:0] {StIdle, StCmd, StArg, StAck} state_e;
  typedef enum logic [1:0] {ModeStatic = 2'd0, ModeBlink = 2'd1, ModeChase = 2'd2} mode_e;

  state_e           st_q;
  mode_e            mode_q;
  logic [7:0]       cmd_q;
  logic [7:0]       pattern_q;
  logic             phase_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic [7:0]       led_data_q;
  logic             led_valid_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             err_q;

  logic       tick;
  logic       cmd_ok;
  logic [7:0] new_pat;
  mode_e      new_mode;

  assign tick   = (tick_cnt_q == TickLast);
  assign cmd_ok = (cmd_q >= CmdStat) && (cmd_q <= CmdClear);

  always_comb begin
    new_pat  = (cmd_q == CmdClear) ? 8'h00 : bus.rx_data;
    new_mode = ModeStatic;
    case (cmd_q)
      CmdBlink: new_mode = ModeBlink;
      CmdChase: new_mode = ModeChase;
      default:  new_mode = ModeStatic;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StIdle;
      mode_q      <= ModeStatic;
      cmd_q       <= 8'h00;
      pattern_q   <= 8'h00;
      phase_q     <= 1'b1;
      tick_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      led_data_q  <= 8'h00;
      led_valid_q <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      led_valid_q <= 1'b0;
      tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;

      // Pattern animation; command execution below overrides these assignments.
      if (tick) begin
        case (mode_q)
          ModeBlink: begin
            phase_q     <= ~phase_q;
            led_data_q  <= phase_q ? 8'h00 : pattern_q;
            led_valid_q <= 1'b1;
          end
          ModeChase: begin
            led_data_q  <= {led_data_q[6:0], led_data_q[7]};
            led_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end

      unique case (st_q)
        StIdle: begin
          if (bus.rx_valid && bus.rx_data == Header) begin
            st_q       <= StCmd;
            idle_cnt_q <= '0;
          end
        end
        StCmd, StArg: begin
          if (bus.rx_valid) begin
            idle_cnt_q <= '0;
            if (st_q == StCmd) begin
              cmd_q <= bus.rx_data;
              st_q  <= StArg;
            end else begin
              st_q       <= StAck;
              tx_valid_q <= 1'b1;
              if (cmd_ok) begin
                tx_data_q   <= RespAck;
                pattern_q   <= new_pat;
                mode_q      <= new_mode;
                phase_q     <= 1'b1;
                led_data_q  <= new_pat;
                led_valid_q <= 1'b1;
                tick_cnt_q  <= '0;
              end else begin
                tx_data_q <= RespNak;
                err_q     <= 1'b1;
              end
            end
          end else if (idle_cnt_q == IdleLast) begin
            // Inter-byte timeout: abandon the frame silently.
            st_q  <= StIdle;
            err_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        StAck: begin
          if (bus.rx_valid) err_q <= 1'b1;
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            st_q       <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign bus.led_data  = led_data_q;
  assign bus.led_valid = led_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.mode      = mode_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with TICK_DIV=4, BYTE_TIMEOUT=8.
// A reference model tracks the sequencer from frame-level rules (pattern, mode,
// ticks elapsed since the last command) and is compared every cycle; literal
// expectations at key points pin the model itself.
module tb_led_pattern_sequencer;
  localparam int TickDiv  = 4;
  localparam int ByteTout = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  led_pattern_sequencer_if bus ();

  led_pattern_sequencer #(
    .TICK_DIV    (TickDiv),
    .BYTE_TIMEOUT(ByteTout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int         m_st;   // 0 idle, 1 expect cmd, 2 expect arg, 3 response pending
  logic [7:0] m_cmd;
  int         m_idle;
  int         m_age;  // cycles since the tick counter last restarted
  int         m_nt;   // ticks since the last executed command
  logic [7:0] m_pat;
  logic [1:0] m_mode;
  logic       m_err;
  logic       m_txv;
  logic [7:0] m_txd;
  logic [7:0] m_led;
  logic       m_ledv;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic model_step();
    bit tick;
    bit ex;
    if (reset) begin
      m_st = 0; m_cmd = 8'h00; m_idle = 0; m_age = 0; m_nt = 0; m_pat = 8'h00;
      m_mode = 2'd0; m_err = 1'b0; m_txv = 1'b0; m_txd = 8'h00; m_led = 8'h00; m_ledv = 1'b0;
    end else begin
      m_ledv = 1'b0;
      m_age++;
      tick = (m_age % TickDiv) == 0;
      ex   = 1'b0;
      case (m_st)
        0: if (bus.rx_valid && bus.rx_data == 8'hA5) begin m_st = 1; m_idle = 0; end
        1, 2: begin
          if (bus.rx_valid) begin
            m_idle = 0;
            if (m_st == 1) begin
              m_cmd = bus.rx_data; m_st = 2;
            end else begin
              m_st = 3; m_txv = 1'b1;
              if (m_cmd >= 8'h01 && m_cmd <= 8'h04) begin
                ex    = 1'b1;
                m_txd = 8'h06;
                m_pat = (m_cmd == 8'h04) ? 8'h00 : bus.rx_data;
                m_mode = (m_cmd == 8'h02) ? 2'd1 : (m_cmd == 8'h03) ? 2'd2 : 2'd0;
                m_age = 0; m_nt = 0; m_led = m_pat; m_ledv = 1'b1;
              end else begin
                m_txd = 8'h15; m_err = 1'b1;
              end
            end
          end else begin
            m_idle++;
            if (m_idle == ByteTout) begin m_st = 0; m_err = 1'b1; end
          end
        end
        default: begin
          if (bus.rx_valid) m_err = 1'b1;
          if (bus.tx_ready) begin m_txv = 1'b0; m_st = 0; end
        end
      endcase
      if (tick && !ex) begin
        m_nt++;
        if (m_mode == 2'd1) begin
          m_led = (m_nt % 2 == 1) ? 8'h00 : m_pat; m_ledv = 1'b1;
        end else if (m_mode == 2'd2) begin
          m_led = rotl(m_pat, m_nt % 8); m_ledv = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model on the edge, compare #1 later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("m_led_data", bus.led_data, m_led);
    chk("m_led_valid", {7'd0, bus.led_valid}, {7'd0, m_ledv});
    chk("m_tx_data", bus.tx_data, m_txd);
    chk("m_tx_valid", {7'd0, bus.tx_valid}, {7'd0, m_txv});
    chk("m_mode", {6'd0, bus.mode}, {6'd0, m_mode});
    chk("m_err", {7'd0, bus.err}, {7'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    cycle();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] a);
    send(8'hA5);
    send(c);
    send(a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  logic [7:0] pulses[$];

  task automatic collect(input int n);
    pulses.delete();
    for (int i = 0; i < n; i++) begin
      cycle();
      if (bus.led_valid) pulses.push_back(bus.led_data);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_led_data", bus.led_data, 8'h00);
    chk("rst_tx_valid", {7'd0, bus.tx_valid}, 8'h00);
    chk("rst_mode", {6'd0, bus.mode}, 8'h00);
    chk("rst_err", {7'd0, bus.err}, 8'h00);

    // Stray bytes in idle are discarded without error.
    send(8'h11); send(8'h5A); idle(2);
    chk("stray_err", {7'd0, bus.err}, 8'h00);

    // Static.
    frame(8'h01, 8'h3C);
    chk("stat_led", bus.led_data, 8'h3C);
    chk("stat_ledv", {7'd0, bus.led_valid}, 8'h01);
    chk("stat_txv", {7'd0, bus.tx_valid}, 8'h01);
    chk("stat_txd", bus.tx_data, 8'h06);
    collect(12);
    chk("stat_pulses", 8'(pulses.size()), 8'd0);

    // Chase: 81 -> 03 -> 06 -> 0C.
    frame(8'h03, 8'h81);
    chk("chase_led", bus.led_data, 8'h81);
    collect(12);
    chk("chase_pulses", 8'(pulses.size()), 8'd3);
    if (pulses.size() == 3) begin
      chk("chase_p0", pulses[0], 8'h03);
      chk("chase_p1", pulses[1], 8'h06);
      chk("chase_p2", pulses[2], 8'h0C);
    end
    chk("chase_mode", {6'd0, bus.mode}, 8'h02);

    // Blink: F0 -> 00 -> F0.
    frame(8'h02, 8'hF0);
    chk("blink_led", bus.led_data, 8'hF0);
    collect(8);
    chk("blink_pulses", 8'(pulses.size()), 8'd2);
    if (pulses.size() == 2) begin
      chk("blink_p0", pulses[0], 8'h00);
      chk("blink_p1", pulses[1], 8'hF0);
    end
    chk("blink_mode", {6'd0, bus.mode}, 8'h01);

    // Unknown command leaves display untouched.
    frame(8'h01, 8'h5A); idle(2);
    frame(8'h07, 8'h11);
    chk("nak_txd", bus.tx_data, 8'h15);
    chk("nak_txv", {7'd0, bus.tx_valid}, 8'h01);
    chk("nak_err", {7'd0, bus.err}, 8'h01);
    chk("nak_led", bus.led_data, 8'h5A);
    chk("nak_ledv", {7'd0, bus.led_valid}, 8'h00);
    chk("nak_mode", {6'd0, bus.mode}, 8'h00);
    idle(2);

    // Reset mid-frame and with a response pending.
    do_reset();
    send(8'hA5); send(8'h01);
    do_reset();
    idle(3);
    chk("rstmid_txv", {7'd0, bus.tx_valid}, 8'h00);
    chk("rstmid_err", {7'd0, bus.err}, 8'h00);
    bus.tx_ready = 1'b0;
    frame(8'h01, 8'h77);
    do_reset();
    chk("rstack_txv", {7'd0, bus.tx_valid}, 8'h00);
    chk("rstack_led", bus.led_data, 8'h00);
    bus.tx_ready = 1'b1;
    idle(2);

    // Inter-byte timeout.
    send(8'hA5);
    idle(7);
    chk("tout_err_before", {7'd0, bus.err}, 8'h00);
    idle(1);
    chk("tout_err_after", {7'd0, bus.err}, 8'h01);
    chk("tout_txv", {7'd0, bus.tx_valid}, 8'h00);
    frame(8'h04, 8'h00);
    chk("clear_led", bus.led_data, 8'h00);
    chk("clear_ledv", {7'd0, bus.led_valid}, 8'h01);
    chk("clear_txd", bus.tx_data, 8'h06);
    idle(2);

    // Response held while tx_ready is low; byte during response is dropped.
    do_reset();
    bus.tx_ready = 1'b0;
    frame(8'h01, 8'h77);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) send(8'h55);
      else cycle();
      chk("hold_txv", {7'd0, bus.tx_valid}, 8'h01);
      chk("hold_txd", bus.tx_data, 8'h06);
    end
    chk("hold_err", {7'd0, bus.err}, 8'h01);
    chk("hold_led", bus.led_data, 8'h77);
    bus.tx_ready = 1'b1;
    cycle();
    chk("release_txv", {7'd0, bus.tx_valid}, 8'h00);
    frame(8'h02, 8'h0F);
    chk("after_led", bus.led_data, 8'h0F);
    chk("after_txv", {7'd0, bus.tx_valid}, 8'h01);
    chk("after_mode", {6'd0, bus.mode}, 8'h01);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
